// File: rtl/atmega_pll_ce.sv
// atmega_pll_ce: PLL control/status register with a lock-delay FSM and
// CHANNELS phase-accumulator clock-enable generators driven from a byte bus.
module atmega_pll_ce #(
  parameter int unsigned BUS_ADDR_DATA_LEN = 16,
  parameter int unsigned PLLCSR_ADDR       = 'h49,
  parameter int unsigned INC_BASE_ADDR     = 'h58,
  parameter int unsigned CHANNELS          = 2,
  parameter int unsigned ACC_WIDTH         = 12,
  parameter int unsigned LOCK_CYCLES       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat,
  input  logic                         wr_dat,
  input  logic                         rd_dat,
  input  logic [7:0]                   bus_dat_in,
  output logic [7:0]                   bus_dat_out,
  output logic                         pll_locked,
  output logic [CHANNELS-1:0]          ce_out
);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_LOCKING,
    ST_LOCKED
  } state_t;

  // Address decode results
  logic                csr_hit;
  logic [CHANNELS-1:0] lo_hit;
  logic [CHANNELS-1:0] hi_hit;
  logic [CHANNELS-1:0] commit;

  // Bus-visible registers
  logic                 plle_q, plle_d;
  logic                 pindiv_q, pindiv_d;
  logic [7:0]           temp_q, temp_d;
  logic [ACC_WIDTH-1:0] inc_q [CHANNELS];
  logic [ACC_WIDTH-1:0] inc_d [CHANNELS];

  // Accumulator datapath
  logic [ACC_WIDTH-1:0] acc_q [CHANNELS];
  logic [ACC_WIDTH-1:0] acc_d [CHANNELS];
  logic [CHANNELS-1:0]  ce_q, ce_d;
  logic                 run;

  // Lock FSM
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  // Decode the bus address against the control register and every increment byte
  always_comb begin
    csr_hit = (addr_dat == BUS_ADDR_DATA_LEN'(PLLCSR_ADDR));
    lo_hit  = '0;
    hi_hit  = '0;
    commit  = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      lo_hit[ch] = (addr_dat == BUS_ADDR_DATA_LEN'(INC_BASE_ADDR + 2 * ch));
      hi_hit[ch] = (addr_dat == BUS_ADDR_DATA_LEN'(INC_BASE_ADDR + 2 * ch + 1));
      commit[ch] = wr_dat && lo_hit[ch];
    end
  end

  // Register writes: high byte parks in the shared TEMP, low byte commits the full increment
  always_comb begin
    plle_d   = plle_q;
    pindiv_d = pindiv_q;
    temp_d   = temp_q;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      inc_d[ch] = inc_q[ch];
    end
    if (wr_dat) begin
      if (csr_hit) begin
        plle_d   = bus_dat_in[1];
        pindiv_d = bus_dat_in[4];
      end
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        if (hi_hit[ch]) begin
          temp_d = bus_dat_in;
        end
        if (commit[ch]) begin
          inc_d[ch] = ACC_WIDTH'({temp_q, bus_dat_in});
        end
      end
    end
  end

  // Bus register storage
  always_ff @(posedge clk) begin
    if (rst) begin
      plle_q   <= 1'b0;
      pindiv_q <= 1'b0;
      temp_q   <= '0;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        inc_q[ch] <= '0;
      end
    end else begin
      plle_q   <= plle_d;
      pindiv_q <= pindiv_d;
      temp_q   <= temp_d;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        inc_q[ch] <= inc_d[ch];
      end
    end
  end

  // Lock FSM state and delay counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Lock FSM next state: the counter reaches zero on the same edge that enters LOCKED
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        cnt_d = '0;
        if (plle_q) begin
          state_d = ST_LOCKING;
          cnt_d   = 8'(LOCK_CYCLES - 1);
        end
      end
      ST_LOCKING: begin
        if (!plle_q) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (cnt_q <= 8'd1) begin
          state_d = ST_LOCKED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_LOCKED: begin
        cnt_d = '0;
        if (!plle_q) begin
          state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Lock FSM outputs; accumulation stops on the same edge the FSM drops to OFF
  always_comb begin
    pll_locked = (state_q == ST_LOCKED);
    run        = (state_q == ST_LOCKED) && plle_q;
  end

  // Phase accumulators: carry out of the widened sum is the enable pulse; a commit clears the channel
  always_comb begin
    logic [ACC_WIDTH:0] sum;
    sum  = '0;
    ce_d = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      acc_d[ch] = '0;
      sum       = {1'b0, acc_q[ch]} + {1'b0, inc_q[ch]};
      if (!commit[ch] && run) begin
        acc_d[ch] = sum[ACC_WIDTH-1:0];
        ce_d[ch]  = sum[ACC_WIDTH];
      end
    end
  end

  // Accumulator and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q <= '0;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        acc_q[ch] <= '0;
      end
    end else begin
      ce_q <= ce_d;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        acc_q[ch] <= acc_d[ch];
      end
    end
  end

  assign ce_out = ce_q;

  // Read mux: high byte returns the committed increment, never the pending TEMP
  always_comb begin
    bus_dat_out = '0;
    if (rd_dat && !rst) begin
      if (csr_hit) begin
        bus_dat_out = {3'b000, pindiv_q, 2'b00, plle_q, pll_locked};
      end
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        if (lo_hit[ch]) begin
          bus_dat_out = inc_q[ch][7:0];
        end
        if (hi_hit[ch]) begin
          bus_dat_out = 8'(16'(inc_q[ch]) >> 8);
        end
      end
    end
  end

endmodule

// File: tb/tb_atmega_pll_ce.sv
// Scoreboard bench for atmega_pll_ce: stimulus pushes expected read data,
// lock transitions and enable-pulse cycles; a negedge monitor pops and compares.
module tb_atmega_pll_ce;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr_dat = '0;
  logic        wr_dat = 1'b0;
  logic        rd_dat = 1'b0;
  logic [7:0]  bus_dat_in = '0;
  logic [7:0]  bus_dat_out;
  logic        pll_locked;
  logic [1:0]  ce_out;

  atmega_pll_ce #(
    .BUS_ADDR_DATA_LEN(16),
    .PLLCSR_ADDR      ('h49),
    .INC_BASE_ADDR    ('h58),
    .CHANNELS         (2),
    .ACC_WIDTH        (12),
    .LOCK_CYCLES      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr_dat   (addr_dat),
    .wr_dat     (wr_dat),
    .rd_dat     (rd_dat),
    .bus_dat_in (bus_dat_in),
    .bus_dat_out(bus_dat_out),
    .pll_locked (pll_locked),
    .ce_out     (ce_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } rd_t;

  typedef struct {
    int   c;
    logic lvl;
  } lk_t;

  rd_t  rdq[$];
  lk_t  lkq[$];
  int   ce0q[$];
  int   ce1q[$];
  logic prev_lock = 1'b0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT output with no expectation queued (cycle %0d)", name, cyc);
  endfunction

  // Monitor: compares every DUT response against the head of its queue
  always @(negedge clk) begin : mon
    rd_t r;
    lk_t l;
    int  e;
    if (cyc >= 1) begin
      if (rd_dat) begin
        if (rdq.size() == 0) unexpected("rd_extra");
        else begin
          r = rdq.pop_front();
          chk(r.name, bus_dat_out, r.exp);
        end
      end
      if (pll_locked !== prev_lock) begin
        if (lkq.size() == 0) unexpected("lock_extra");
        else begin
          l = lkq.pop_front();
          chk("lock_cycle", cyc, l.c);
          chk("lock_level", pll_locked, l.lvl);
        end
        prev_lock = pll_locked;
      end
      if (ce_out[0]) begin
        if (ce0q.size() == 0) unexpected("ce0_extra");
        else begin
          e = ce0q.pop_front();
          chk("ce0_cycle", cyc, e);
        end
      end
      if (ce_out[1]) begin
        if (ce1q.size() == 0) unexpected("ce1_extra");
        else begin
          e = ce1q.pop_front();
          chk("ce1_cycle", cyc, e);
        end
      end
    end
  end

  task automatic goto(int c);
    if (cyc > c) begin
      errors++;
      $display("FAIL schedule: at cycle %0d, wanted %0d", cyc, c);
    end
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Write committed on rising edge number c
  task automatic write_at(int c, logic [15:0] a, logic [7:0] d);
    goto(c - 1);
    addr_dat   = a;
    bus_dat_in = d;
    wr_dat     = 1'b1;
    @(posedge clk);
    #1;
    wr_dat = 1'b0;
  endtask

  // Read presented in the cycle following rising edge number c
  task automatic read_at(int c, logic [15:0] a, logic [7:0] e, string n);
    goto(c);
    rdq.push_back(rd_t'{name: n, exp: e});
    addr_dat = a;
    rd_dat   = 1'b1;
    @(posedge clk);
    #1;
    rd_dat = 1'b0;
  endtask

  initial begin
    #80000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state; reads are masked while rst is high
    read_at(2, 'h49, 'h00, "rd_csr_in_rst");
    chk("rst_locked", pll_locked, 0);
    chk("rst_ce", ce_out, 0);
    rst = 1'b0;
    read_at(4, 'h49, 'h00, "rd_csr_rst");
    read_at(5, 'h58, 'h00, "rd_inc0lo_rst");
    read_at(6, 'h59, 'h00, "rd_inc0hi_rst");
    read_at(7, 'h5A, 'h00, "rd_inc1lo_rst");
    read_at(8, 'h5B, 'h00, "rd_inc1hi_rst");
    read_at(9, 'h50, 'h00, "rd_unmapped_rst");

    // INC0 = 0x400 via TEMP; high-byte read ignores pending TEMP
    write_at(11, 'h59, 'h04);
    read_at(11, 'h59, 'h00, "rd_hi_not_temp");
    write_at(13, 'h58, 'h00);
    read_at(13, 'h58, 'h00, "rd_inc0lo");
    read_at(14, 'h59, 'h04, "rd_inc0hi");

    // PLLCSR=0x13 at edge 17: lock at 33, ch0 pulses every 4 from 37, off at 73 -> falls at 74
    write_at(17, 'h49, 'h13);
    lkq.push_back(lk_t'{c: 33, lvl: 1'b1});
    lkq.push_back(lk_t'{c: 74, lvl: 1'b0});
    for (int c = 37; c <= 73; c += 4) ce0q.push_back(c);
    read_at(17, 'h49, 'h12, "rd_csr_prelock");
    read_at(34, 'h49, 'h13, "rd_csr_locked");
    read_at(36, 'h5C, 'h00, "rd_unmapped_5c");
    read_at(37, 'h48, 'h00, "rd_unmapped_48");
    write_at(73, 'h49, 'h00);
    read_at(75, 'h49, 'h00, "rd_csr_off");

    // Abort mid-lock (counter 5 at edge 91): no lock must appear
    write_at(80, 'h49, 'h02);
    write_at(91, 'h49, 'h00);
    write_at(94, 'h5B, 'h0F);
    write_at(95, 'h5A, 'hFF);
    read_at(95, 'h5A, 'hFF, "rd_inc1lo");
    read_at(96, 'h5B, 'h0F, "rd_inc1hi");
    read_at(97, 'h49, 'h00, "rd_csr_aborted");

    // Full relock from edge 100 -> lock at 116
    write_at(100, 'h49, 'h02);
    lkq.push_back(lk_t'{c: 116, lvl: 1'b1});
    lkq.push_back(lk_t'{c: 4220, lvl: 1'b0});
    for (int c = 120; c <= 196; c += 4) ce0q.push_back(c);
    // INC0 -> 0x200 committed at edge 200, exactly when a ch0 carry was due
    for (int c = 208; c <= 4219; c += 8) ce0q.push_back(c);
    // INC1 = 0xFFF: high every locked cycle except k=1 and k=4097
    for (int k = 2; k <= 4103; k++) begin
      if (k != 4097) ce1q.push_back(116 + k);
    end
    write_at(199, 'h59, 'h02);
    write_at(200, 'h58, 'h00);
    read_at(201, 'h58, 'h00, "rd_inc0lo_new");
    read_at(202, 'h59, 'h02, "rd_inc0hi_new");
    read_at(203, 'h5B, 'h0F, "rd_inc1hi_keep");

    // Reset at edge 4220 while locked, with a competing PLLE write and read
    goto(4219);
    rdq.push_back(rd_t'{name: "rd_during_rst", exp: 'h00});
    rst        = 1'b1;
    wr_dat     = 1'b1;
    rd_dat     = 1'b1;
    addr_dat   = 'h49;
    bus_dat_in = 'h02;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    wr_dat = 1'b0;
    rd_dat = 1'b0;
    chk("post_rst_locked", pll_locked, 0);
    chk("post_rst_ce", ce_out, 0);
    read_at(4220, 'h49, 'h00, "rd_csr_post_rst");
    read_at(4221, 'h58, 'h00, "rd_inc0lo_post_rst");
    read_at(4222, 'h59, 'h00, "rd_inc0hi_post_rst");
    read_at(4223, 'h5A, 'h00, "rd_inc1lo_post_rst");
    read_at(4224, 'h5B, 'h00, "rd_inc1hi_post_rst");
    goto(4262);

    chk("rdq_left", rdq.size(), 0);
    chk("lkq_left", lkq.size(), 0);
    chk("ce0q_left", ce0q.size(), 0);
    chk("ce1q_left", ce1q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
